// File: rtl/candy_pkg.sv
// Shared constants, types and helpers for the candy vending machine.
package candy_pkg;

   localparam int NUM_ITEMS          = 5;
   localparam int CREDIT_W           = 7;
   localparam int DEFAULT_MAX_CREDIT = 99;

   // Item prices in 100-units, item 0 in the low slice; ascending so the highest affordable index is the dearest.
   localparam logic [NUM_ITEMS-1:0][CREDIT_W-1:0] PRICE = {7'd7, 7'd5, 7'd3, 7'd2, 7'd1};

   localparam int KEY_COIN100 = 0;
   localparam int KEY_COIN500 = 1;
   localparam int KEY_CHANGE  = 2;
   localparam int KEY_VEND    = 3;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_COIN100,
      ACT_COIN500,
      ACT_VEND,
      ACT_CHANGE
   } action_e;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   // Repeated subtraction; credit never exceeds 99, so nine steps always suffice.
   function automatic bcd_t to_bcd(input logic [CREDIT_W-1:0] bin);
      logic [CREDIT_W-1:0] rem;
      bcd_t                r;
      rem    = bin;
      r.tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem    = rem - 7'd10;
            r.tens = r.tens + 4'd1;
         end
      end
      r.ones = 4'(rem);
      return r;
   endfunction

endpackage

// File: rtl/candy_seg7_decoder.sv
// Decimal digit to 7-segment pattern {dp,g,f,e,d,c,b,a}, active-high, dp always off.
module candy_seg7_decoder
   import candy_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [7:0] seg
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (value)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/candy_top.sv
// Candy vending machine: key edge detect, credit/purchase datapath and 8-digit scanned display.
module candy_top
   import candy_pkg::*;
#(
   parameter int SCAN_DIV   = 0,
   parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_in,
   output logic [7:0] display_column,
   output logic [7:0] out,
   output logic [2:0] col,
   output logic [4:0] can_buy
);

   localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

   logic [3:0]          key_prev;
   logic [3:0]          key_edge;
   logic [CREDIT_W-1:0] credit;
   logic [2:0]          last_item;
   logic                scan_tick;
   action_e             action;
   logic                vend_ok;
   logic [2:0]          vend_idx;
   logic [CREDIT_W:0]   credit_add;
   bcd_t                credit_bcd;
   logic [3:0]          digit;
   logic                digit_blank;

   assign key_edge = key_in & ~key_prev;

   // Only the highest-priority edge acts; the rest of that cycle's edges are dropped.
   always_comb begin
      action = ACT_NONE;
      if (key_edge[KEY_CHANGE])       action = ACT_CHANGE;
      else if (key_edge[KEY_VEND])    action = ACT_VEND;
      else if (key_edge[KEY_COIN500]) action = ACT_COIN500;
      else if (key_edge[KEY_COIN100]) action = ACT_COIN100;
   end

   always_comb begin
      can_buy = '0;
      for (int i = 0; i < NUM_ITEMS; i++) can_buy[i] = (credit >= PRICE[i]);
   end

   always_comb begin
      vend_ok  = 1'b0;
      vend_idx = 3'd0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (can_buy[i]) begin
            vend_ok  = 1'b1;
            vend_idx = 3'(i);
         end
      end
   end

   assign credit_add = {1'b0, credit} + ((action == ACT_COIN500) ? 8'd5 : 8'd1);

   generate
      if (SCAN_DIV == 0) begin : g_scan_every_clk
         assign scan_tick = 1'b1;
      end else begin : g_scan_div
         logic [SCAN_DIV-1:0] scan_cnt;
         always_ff @(posedge clk) begin
            if (reset) scan_cnt <= '0;
            else       scan_cnt <= scan_cnt + SCAN_DIV'(1);
         end
         assign scan_tick = &scan_cnt;
      end
   endgenerate

   // NOTE: registers use <= so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_prev  <= '0;
         credit    <= '0;
         last_item <= '0;
         col       <= '0;
      end else begin
         key_prev <= key_in;
         if (scan_tick) col <= col + 3'd1;
         case (action)
            ACT_CHANGE: begin
               credit    <= '0;
               last_item <= '0;
            end
            ACT_VEND: begin
               if (vend_ok) begin
                  credit    <= credit - PRICE[vend_idx];
                  last_item <= vend_idx + 3'd1;
               end
            end
            ACT_COIN100, ACT_COIN500: begin
               if (credit_add <= MAX_C) credit <= credit_add[CREDIT_W-1:0];
            end
            default: ;
         endcase
      end
   end

   assign credit_bcd     = to_bcd(credit);
   assign display_column = 8'b1 << col;

   always_comb begin
      digit       = 4'd0;
      digit_blank = 1'b1;
      case (col)
         3'd0, 3'd1: digit_blank = 1'b0;
         3'd2: begin
            digit       = credit_bcd.ones;
            digit_blank = 1'b0;
         end
         3'd3: begin
            digit       = credit_bcd.tens;
            digit_blank = (credit_bcd.tens == 4'd0);
         end
         3'd7: begin
            digit       = {1'b0, last_item};
            digit_blank = (last_item == 3'd0);
         end
         default: ;
      endcase
   end

   candy_seg7_decoder u_seg7 (
      .value (digit),
      .blank (digit_blank),
      .seg   (out)
   );

endmodule

// File: tb/tb_candy_top.sv
// Self-checking bench for candy_top: directed scenarios plus random key presses against a credit model.
module tb_candy_top;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic [3:0] key_in = 4'b0;
   logic [7:0] display_column;
   logic [7:0] out;
   logic [2:0] col;
   logic [4:0] can_buy;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int m_credit = 0;
   int m_last   = 0;
   int m_col    = 0;

   int         price   [5]  = '{1, 2, 3, 5, 7};
   logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   wire [23:0] dut_vec = {display_column, out, col, can_buy};

   always #5 clk = ~clk;

   candy_top #(.SCAN_DIV(0), .MAX_CREDIT(99)) dut (
      .clk            (clk),
      .reset          (reset),
      .key_in         (key_in),
      .display_column (display_column),
      .out            (out),
      .col            (col),
      .can_buy        (can_buy)
   );

   always @(posedge clk) begin
      if (reset) m_col <= 0;
      else       m_col <= (m_col + 1) % 8;
   end

   function automatic void model_key(input logic [3:0] k);
      if (k[2]) begin
         m_credit = 0;
         m_last   = 0;
      end else if (k[3]) begin
         for (int i = 4; i >= 0; i--) begin
            if (m_credit >= price[i]) begin
               m_credit -= price[i];
               m_last    = i + 1;
               break;
            end
         end
      end else if (k[1]) begin
         if (m_credit + 5 <= 99) m_credit += 5;
      end else if (k[0]) begin
         if (m_credit + 1 <= 99) m_credit += 1;
      end
   endfunction

   function automatic logic [23:0] exp_vec();
      logic [7:0] seg;
      logic [4:0] can;
      int ones;
      int tens;
      ones = m_credit % 10;
      tens = m_credit / 10;
      case (m_col)
         0, 1:    seg = seg_tbl[0];
         2:       seg = seg_tbl[ones];
         3:       seg = (tens == 0) ? 8'h00 : seg_tbl[tens];
         7:       seg = (m_last == 0) ? 8'h00 : seg_tbl[m_last];
         default: seg = 8'h00;
      endcase
      for (int i = 0; i < 5; i++) can[i] = (m_credit >= price[i]);
      return {8'(1 << m_col), seg, 3'(m_col), can};
   endfunction

   task automatic press(input logic [3:0] k, input int hold);
      @(negedge clk);
      key_in = k;
      model_key(k);
      repeat (hold) @(negedge clk);
      key_in = 4'b0;
   endtask

   task automatic wait_col(input int c);
      for (int n = 0; n < 8 && m_col != c; n++) @(negedge clk);
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      key_in = 4'b0;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (dut_vec !== {8'h01, 8'h3F, 3'd0, 5'b00000})
         $display("FAIL reset_state: got %h want %h", dut_vec, {8'h01, 8'h3F, 3'd0, 5'b00000});
      else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_scan();
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL scan[%0d]: got %h want %h", k, dut_vec, exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_coin_pulse();
      press(4'b0010, 3);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL coin500_pulse: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
      chk_cnt++;
      if (can_buy !== 5'b01111) $display("FAIL coin500_can_buy: got %b want 01111", can_buy);
      else pass_cnt++;
      wait_col(2);
      chk_cnt++;
      if (out !== 8'h6D) $display("FAIL coin500_col2: got %h want 6d", out);
      else pass_cnt++;
   endtask

   task automatic test_vend_sequence();
      press(4'b0100, 1);
      press(4'b0010, 1);
      press(4'b0010, 2);
      press(4'b0001, 1);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL credit_11: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
      press(4'b1000, 1);
      chk_cnt++;
      if (can_buy !== 5'b00111) $display("FAIL vend_item4_can_buy: got %b want 00111", can_buy);
      else pass_cnt++;
      wait_col(7);
      chk_cnt++;
      if (out !== 8'h6D) $display("FAIL vend_item4_col7: got %h want 6d", out);
      else pass_cnt++;
      for (int v = 0; v < 3; v++) begin
         press(4'b1000, 1);
         chk_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL vend_step%0d: got %h want %h", v, dut_vec, exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_ceiling();
      press(4'b0100, 1);
      for (int n = 0; n < 19; n++) press(4'b0010, 1);
      for (int n = 0; n < 3; n++) press(4'b0001, 1);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL credit_98: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
      press(4'b0010, 1);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL coin500_rejected: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
      press(4'b0001, 1);
      wait_col(3);
      chk_cnt++;
      if (out !== 8'h6F) $display("FAIL credit_99_tens: got %h want 6f", out);
      else pass_cnt++;
      press(4'b0100, 2);
      wait_col(7);
      chk_cnt++;
      if (out !== 8'h00) $display("FAIL change_col7_blank: got %h want 00", out);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      press(4'b0010, 1);
      press(4'b1111, 1);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL same_cycle_change: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
      chk_cnt++;
      if (can_buy !== 5'b00000) $display("FAIL same_cycle_can_buy: got %b want 00000", can_buy);
      else pass_cnt++;
   endtask

   task automatic test_key_after_reset();
      @(negedge clk);
      reset  = 1'b1;
      key_in = 4'b0001;
      repeat (2) @(negedge clk);
      m_credit = 0;
      m_last   = 0;
      reset    = 1'b0;
      model_key(4'b0001);
      @(negedge clk);
      key_in = 4'b0;
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL key_held_from_reset: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         press(4'($urandom_range(0, 15)), $urandom_range(1, 3));
         chk_cnt++;
         if (dut_vec !== exp_vec()) $display("FAIL random[%0d]: got %h want %h", n, dut_vec, exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      press(4'b0010, 1);
      press(4'b0010, 1);
      press(4'b1000, 1);
      @(negedge clk);
      reset  = 1'b1;
      key_in = 4'b0010;
      @(negedge clk);
      m_credit = 0;
      m_last   = 0;
      chk_cnt++;
      if (dut_vec !== {8'h01, 8'h3F, 3'd0, 5'b00000})
         $display("FAIL reset_mid: got %h want %h", dut_vec, {8'h01, 8'h3F, 3'd0, 5'b00000});
      else pass_cnt++;
      reset  = 1'b0;
      key_in = 4'b0;
      @(negedge clk);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL after_reset_mid: got %h want %h", dut_vec, exp_vec());
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_coin_pulse();
      test_vend_sequence();
      test_ceiling();
      test_same_cycle();
      test_key_after_reset();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
